// File: rtl/spi_flash_responder_pkg.sv
// Shared types and frame constants for the SPI flash read responder.
package spi_flash_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;
  localparam int         CNT_W     = 5;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Multi-flop synchroniser for one SPI pin, with rise/fall strobes on the synchronised copy.
module spi_in_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES:0]   r_fill;
  logic              r_prev;

  // r_fill marks when the chain and r_prev hold real pin samples, so the
  // reset value is never mistaken for an edge (e.g. CS held low across reset).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_fill <= '0;
      r_prev <= RESET_VAL;
    end else begin
      r_sync[0] <= i_d;
      r_fill[0] <= 1'b1;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      for (int i = 1; i <= STAGES; i++) r_fill[i] <= r_fill[i-1];
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_fill[STAGES] & o_q & ~r_prev;
  assign o_fall = r_fill[STAGES] & ~o_q & r_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator answering READ (0x03) with sequential bytes from a backing ROM.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic              cmd_err
);

  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(clk), .i_reset(reset), .i_d(spi_cs_n),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk(clk), .i_reset(reset), .i_d(spi_sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(clk), .i_reset(reset), .i_d(spi_mosi),
    .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  assign w_unused = ^{w_cs_q, w_sclk_q, w_mosi_rise, w_mosi_fall};

  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [ADDR_BITS-1:0]   r_shift, w_shift_next;
  logic [ADDR_W-1:0]      r_rom_addr;
  logic [7:0]             r_tx;
  logic                   r_miso, r_fetch, r_cmd_err;
  logic                   w_cmd_err, w_addr_done, w_byte_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // CS rise is checked first so a coincident SCLK edge is dropped.
  always_comb begin
    w_state_next = r_state;
    w_cmd_err    = 1'b0;
    w_addr_done  = 1'b0;
    w_byte_done  = 1'b0;
    w_shift_next = {r_shift[ADDR_BITS-2:0], w_mosi};
    if (w_cs_rise) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_state_next = ST_CMD;
        ST_CMD: begin
          if (w_sclk_rise && r_bit_cnt == CMD_LAST) begin
            if (w_shift_next[7:0] == CMD_READ) begin
              w_state_next = ST_ADDR;
            end else begin
              w_state_next = ST_IGNORE;
              w_cmd_err    = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (w_sclk_rise && r_bit_cnt == ADDR_LAST) begin
            w_state_next = ST_DATA;
            w_addr_done  = 1'b1;
          end
        end
        ST_DATA: if (w_sclk_rise && r_bit_cnt == BYTE_LAST) w_byte_done = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rom_addr <= '0;
      r_tx       <= '0;
      r_miso     <= 1'b1;
      r_fetch    <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_err;
      r_fetch   <= w_addr_done | w_byte_done;

      if (w_state_next != r_state)
        r_bit_cnt <= '0;
      else if (w_sclk_rise && (r_state == ST_CMD || r_state == ST_ADDR || r_state == ST_DATA))
        r_bit_cnt <= w_byte_done ? '0 : r_bit_cnt + CNT_W'(1);

      if (r_state == ST_IDLE)
        r_shift <= '0;
      else if (w_sclk_rise && !w_cs_rise && (r_state == ST_CMD || r_state == ST_ADDR))
        r_shift <= w_shift_next;

      if (w_addr_done)      r_rom_addr <= w_shift_next[ADDR_W-1:0];
      else if (w_byte_done) r_rom_addr <= r_rom_addr + ADDR_W'(1);

      if (r_state != ST_DATA) begin
        r_miso <= 1'b1;
      end else if (w_sclk_fall && !w_cs_rise) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      // ROM byte lands one clk after the address moves; SCLK timing keeps it clear of any fall.
      if (r_fetch) r_tx <= rom_data;
    end
  end

  assign spi_miso = (r_state == ST_DATA) ? r_miso : 1'b1;
  assign rom_addr = r_rom_addr;
  assign busy     = (r_state != ST_IDLE);
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench: SPI controller model pushes expected MISO bytes, a monitor compares received ones.
module tb_spi_flash_responder;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs_n, spi_sclk, spi_mosi;
  logic        spi_miso;
  logic [23:0] rom_addr;
  logic [7:0]  rom_data;
  logic        busy, cmd_err;

  spi_flash_responder #(.ADDR_W(24), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .cmd_err(cmd_err));

  always #5 clk = ~clk;

  assign rom_data = rom_addr[7:0] ^ 8'hA5;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rx_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         half     = 7;
  int         err_pulses = 0;
  logic       watch = 1'b0;
  int         bad_addr = 0;

  always @(posedge clk) if (cmd_err) err_pulses <= err_pulses + 1;

  always @(negedge clk)
    if (watch && rom_addr != 24'h000001 && rom_addr != 24'h000020 && rom_addr != 24'h000021)
      bad_addr <= bad_addr + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      while (rx_q.size() != 0) begin
        got = rx_q.pop_front();
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL miso_unexpected: got 0x%02h with nothing expected", got);
        end else begin
          e = exp_q.pop_front();
          check(e.name, 32'(got), 32'(e.val));
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (half) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp, input string name);
    logic [7:0] rx;
    exp_t e;
    e.name = name;
    e.val  = exp;
    exp_q.push_back(e);
    spi_bits(tx, 8, rx);
    rx_q.push_back(rx);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (half) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4 * half) @(negedge clk);
  endtask

  task automatic send_read_hdr(input logic [23:0] addr, input string tag);
    spi_byte(8'h03, 8'hFF, {tag, "_cmd_miso"});
    spi_byte(addr[23:16], 8'hFF, {tag, "_a2_miso"});
    spi_byte(addr[15:8], 8'hFF, {tag, "_a1_miso"});
    spi_byte(addr[7:0], 8'hFF, {tag, "_a0_miso"});
  endtask

  // exp_data holds the expected bytes packed from the top, byte 0 in [23:16].
  task automatic do_read(input logic [23:0] addr, input int nbytes,
                         input logic [23:0] exp_data, input string tag);
    cs_low();
    send_read_hdr(addr, tag);
    for (int b = 0; b < nbytes; b++)
      spi_byte(8'h00, exp_data[23-8*b -: 8], {tag, "_data"});
    check({tag, "_busy_active"}, 32'(busy), 32'd1);
    cs_high();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: run did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         cnt;
    int         pulses0;
    logic [7:0] junk;

    reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_miso", 32'(spi_miso), 32'd1);
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    check("reset_cmd_err", 32'(cmd_err), 32'd0);
    repeat (10) @(negedge clk);

    // sequential read burst
    do_read(24'h000010, 3, 24'hB5B4B7, "burst");
    check("burst_rom_addr_end", 32'(rom_addr), 32'h000013);
    check("burst_busy_idle", 32'(busy), 32'd0);

    // unsupported command: MISO stays high across 40 SCLKs
    pulses0 = err_pulses;
    cs_low();
    spi_byte(8'h0B, 8'hFF, "badcmd_miso");
    for (int b = 0; b < 4; b++) spi_byte(8'h5A, 8'hFF, "badcmd_miso");
    check("badcmd_busy", 32'(busy), 32'd1);
    repeat (half) @(negedge clk);
    spi_cs_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt++;
      if (!busy) break;
    end
    check("badcmd_busy_drop_clks", 32'(cnt), 32'(SYNC_STAGES + 1));
    check("badcmd_err_pulses", 32'(err_pulses - pulses0), 32'd1);
    repeat (4 * half) @(negedge clk);

    // address wrap at top of space
    do_read(24'hFFFFFF, 2, 24'h5AA500, "wrap");
    check("wrap_rom_addr_end", 32'(rom_addr), 32'h000001);

    // abort mid-address, then a clean read
    watch = 1'b1;
    cs_low();
    spi_byte(8'h03, 8'hFF, "abort_cmd_miso");
    spi_byte(8'hAB, 8'hFF, "abort_a2_miso");
    spi_bits(8'hCD, 5, junk);
    cs_high();
    check("abort_rom_addr_hold", 32'(rom_addr), 32'h000001);
    check("abort_busy", 32'(busy), 32'd0);
    do_read(24'h000020, 1, 24'h850000, "after_abort");
    watch = 1'b0;
    check("abort_no_partial_addr", 32'(bad_addr), 32'd0);
    check("after_abort_rom_addr", 32'(rom_addr), 32'h000021);

    // reset during DATA bit 4 with CS held low
    cs_low();
    send_read_hdr(24'h000040, "rst");
    spi_bits(8'h00, 4, junk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_miso", 32'(spi_miso), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    repeat (4) @(negedge clk);
    spi_byte(8'h03, 8'hFF, "rst_cs_low_miso");
    spi_byte(8'h00, 8'hFF, "rst_cs_low_miso");
    check("rst_cs_low_busy", 32'(busy), 32'd0);
    check("rst_cs_low_rom_addr", 32'(rom_addr), 32'h0);
    cs_high();
    do_read(24'h000005, 1, 24'hA00000, "rst_retry");

    // fastest allowed SCLK
    half = SYNC_STAGES + 3;
    do_read(24'h000100, 3, 24'hA5A4A7, "mintime");
    check("mintime_rom_addr_end", 32'(rom_addr), 32'h000103);

    cnt = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_drained", 32'(exp_q.size() + rx_q.size()), 32'd0);
    check("cmd_err_total", 32'(err_pulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
